// File: rtl/cnn_seq_pkg.sv
// Shared state codes, stage codes and mask helpers for the CNN layer sequencer.
package cnn_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CONV   = 3'd1;
  localparam logic [2:0] ST_POOL   = 3'd2;
  localparam logic [2:0] ST_FC     = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [1:0] STG_IDLE = 2'd0;
  localparam logic [1:0] STG_CONV = 2'd1;
  localparam logic [1:0] STG_POOL = 2'd2;
  localparam logic [1:0] STG_FC   = 2'd3;

  localparam int MASK_CONV = 0;
  localparam int MASK_POOL = 1;
  localparam int MASK_FC   = 2;

  // Stages still eligible once the named stage has completed.
  localparam logic [2:0] AFTER_CONV = 3'b110;
  localparam logic [2:0] AFTER_POOL = 3'b100;

  function automatic logic [2:0] next_enabled(input logic [2:0] mask);
    logic [2:0] st;
    if (mask[MASK_CONV])      st = ST_CONV;
    else if (mask[MASK_POOL]) st = ST_POOL;
    else if (mask[MASK_FC])   st = ST_FC;
    else                      st = ST_FINISH;
    return st;
  endfunction

  function automatic logic [1:0] stage_code(input logic [2:0] st);
    logic [1:0] code;
    case (st)
      ST_CONV: code = STG_CONV;
      ST_POOL: code = STG_POOL;
      ST_FC:   code = STG_FC;
      default: code = STG_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_stage(input logic [2:0] st);
    return (st == ST_CONV) || (st == ST_POOL) || (st == ST_FC);
  endfunction

endpackage

// File: rtl/cnn_seq_watchdog.sv
// Per-stage watchdog: loadable down-counter, armed on load, disarmed on clear.
module cnn_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          armed;

  // Loaded with TIMEOUT-1 so expiry lands on the TIMEOUT-th cycle of the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(TIMEOUT_CYCLES - 1);
      armed <= 1'b1;
    end else if (armed && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = armed && (cnt == '0);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Runs one inference job through conv -> pool -> fc engines in order.
// Optional per-stage watchdog enabled by defining CNN_SEQ_WATCHDOG_EN.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           layer_mask,
  output logic                 conv_valid_in,
  input  logic                 conv_valid_out,
  output logic                 pool_valid_in,
  input  logic                 pool_valid_out,
  output logic                 en,
  input  logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           stage,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  // Handshake: each launch output is a one-cycle pulse in the first cycle of
  // its stage (en is a level for the FC stage); a completion strobe counts only
  // when its engine is active and it is not the launch cycle itself.

  logic [2:0] state, state_nxt;
  logic [2:0] mask_q, mask_nxt;
  logic       entry_q;
  logic       accept;
  logic       timeout;
  logic       wd_expired;

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_q;
    accept    = 1'b0;
    timeout   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          accept    = 1'b1;
          mask_nxt  = layer_mask;
          state_nxt = next_enabled(layer_mask);
        end
        ST_CONV: begin
          if (conv_valid_out && !entry_q) state_nxt = next_enabled(mask_q & AFTER_CONV);
          else if (wd_expired) begin timeout = 1'b1; state_nxt = ST_FINISH; end
        end
        ST_POOL: begin
          if (pool_valid_out && !entry_q) state_nxt = next_enabled(mask_q & AFTER_POOL);
          else if (wd_expired) begin timeout = 1'b1; state_nxt = ST_FINISH; end
        end
        ST_FC: begin
          if (valid && !entry_q) state_nxt = ST_FINISH;
          else if (wd_expired) begin timeout = 1'b1; state_nxt = ST_FINISH; end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mask_q        <= '0;
      entry_q       <= 1'b0;
      conv_valid_in <= 1'b0;
      pool_valid_in <= 1'b0;
      en            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      stage         <= STG_IDLE;
      cycle_count   <= '0;
    end else begin
      state         <= state_nxt;
      mask_q        <= mask_nxt;
      entry_q       <= (state_nxt != state);
      conv_valid_in <= (state_nxt == ST_CONV) && (state != ST_CONV);
      pool_valid_in <= (state_nxt == ST_POOL) && (state != ST_POOL);
      en            <= (state_nxt == ST_FC);
      busy          <= is_stage(state_nxt);
      done          <= (state_nxt == ST_FINISH);
      stage         <= stage_code(state_nxt);
      if (accept)
        cycle_count <= '0;
      else if (busy && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
    end
  end

`ifdef CNN_SEQ_WATCHDOG_EN
  logic error_q;

  cnn_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (is_stage(state_nxt) && (state_nxt != state)),
    .clear  (!is_stage(state_nxt)),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       error_q <= 1'b0;
    else if (accept)  error_q <= 1'b0;
    else if (timeout) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign wd_expired = 1'b0;
  assign error      = 1'b0;
`endif

endmodule
